// File: rtl/peak_pkg.sv
// Shared types and constants for the peak_window block: FSM states,
// counter width and default sample/window sizes.
package peak_pkg;

  localparam int COUNT_W    = 8;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_WINDOW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/mag_max2.sv
// Two-input unsigned magnitude comparator: returns the larger value and a
// strict a>b flag, so equal inputs resolve to b.
module mag_max2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] max,
  output logic             a_gt_b
);

  assign a_gt_b = (a > b);
  assign max    = a_gt_b ? a : b;

endmodule

// File: rtl/peak_window.sv
// Windowed peak detector: finds the largest of WINDOW unsigned samples and
// holds it for a valid/ready handshake. Define PEAK_INDEX_EN for out_idx.
module peak_window
  import peak_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PEAK_INDEX_EN
  output logic [7:0]       out_idx,
`endif
  output logic [WIDTH-1:0] out_max
);

  localparam logic [COUNT_W-1:0] WIN_C = COUNT_W'(WINDOW);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   max_q, max_d;
  logic               live_q;
  logic               accept;
  logic [WIDTH-1:0]   cmpMax;
  logic               cmpGt;
`ifdef PEAK_INDEX_EN
  logic [7:0]         idx_q, idx_d;
`endif

  mag_max2 #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a      (in_data),
    .b      (max_q),
    .max    (cmpMax),
    .a_gt_b (cmpGt)
  );

  // Holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      max_q   <= '0;
`ifdef PEAK_INDEX_EN
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      max_q   <= max_d;
`ifdef PEAK_INDEX_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign in_ready = live_q && (state_q != HOLD);
  assign accept   = in_valid && in_ready;

  // clr overrides both sample acceptance and the output handshake.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    max_d   = max_q;
`ifdef PEAK_INDEX_EN
    idx_d   = idx_q;
`endif
    if (clr) begin
      state_d = IDLE;
      count_d = '0;
      max_d   = '0;
`ifdef PEAK_INDEX_EN
      idx_d   = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            max_d   = in_data;
            count_d = COUNT_W'(1);
`ifdef PEAK_INDEX_EN
            idx_d   = '0;
`endif
            state_d = (WIN_C == COUNT_W'(1)) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (cmpGt) begin
              max_d = cmpMax;
`ifdef PEAK_INDEX_EN
              idx_d = count_q;
`endif
            end
            count_d = count_q + COUNT_W'(1);
            if ((count_q + COUNT_W'(1)) == WIN_C) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            count_d = '0;
            max_d   = '0;
`ifdef PEAK_INDEX_EN
            idx_d   = '0;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
          max_d   = '0;
        end
      endcase
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_max   = out_valid ? max_q : '0;
`ifdef PEAK_INDEX_EN
  assign out_idx   = out_valid ? idx_q : '0;
`endif

endmodule

// File: tb/tb_peak_window.sv
// Directed bench for peak_window: one WINDOW=4 instance driven from a vector
// table plus hand sequences, and one WINDOW=1 instance for the single-sample case.
module tb_peak_window;

  logic       clk;
  logic       rst_n;
  logic       clrA, inValidA, outReadyA, inReadyA, outValidA;
  logic [7:0] inDataA, outMaxA;
  logic       clrB, inValidB, outReadyB, inReadyB, outValidB;
  logic [7:0] inDataB, outMaxB;
`ifdef PEAK_INDEX_EN
  logic [7:0] outIdxA, outIdxB;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       c;
    logic       o;
    logic       er;
    logic       ev;
    logic [7:0] em;
    logic [7:0] ei;
  } vec_t;

  vec_t vecs[$];

  peak_window #(.WIDTH(8), .WINDOW(4)) dutA (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clrA),
    .in_valid  (inValidA),
    .in_data   (inDataA),
    .in_ready  (inReadyA),
    .out_valid (outValidA),
    .out_ready (outReadyA),
`ifdef PEAK_INDEX_EN
    .out_idx   (outIdxA),
`endif
    .out_max   (outMaxA)
  );

  peak_window #(.WIDTH(8), .WINDOW(1)) dutB (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clrB),
    .in_valid  (inValidB),
    .in_data   (inDataB),
    .in_ready  (inReadyB),
    .out_valid (outValidB),
    .out_ready (outReadyB),
`ifdef PEAK_INDEX_EN
    .out_idx   (outIdxB),
`endif
    .out_max   (outMaxB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic er, input logic ev,
                             input logic [7:0] em, input logic [7:0] ei);
    chk({name, ".in_ready"}, 32'(inReadyA), 32'(er));
    chk({name, ".out_valid"}, 32'(outValidA), 32'(ev));
    chk({name, ".out_max"}, 32'(outMaxA), 32'(em));
`ifdef PEAK_INDEX_EN
    chk({name, ".out_idx"}, 32'(outIdxA), 32'(ei));
`else
    if (ei === 8'hxx) $display("[TB] unused index %0h", ei);
`endif
  endtask

  task automatic checkB(input string name, input logic er, input logic ev,
                        input logic [7:0] em, input logic [7:0] ei);
    chk({name, ".B.in_ready"}, 32'(inReadyB), 32'(er));
    chk({name, ".B.out_valid"}, 32'(outValidB), 32'(ev));
    chk({name, ".B.out_max"}, 32'(outMaxB), 32'(em));
`ifdef PEAK_INDEX_EN
    chk({name, ".B.out_idx"}, 32'(outIdxB), 32'(ei));
`else
    if (ei === 8'hxx) $display("[TB] unused index %0h", ei);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t r);
    inValidA  = r.v;
    inDataA   = r.d;
    clrA      = r.c;
    outReadyA = r.o;
  endtask

  task automatic addRow(input logic v, input logic [7:0] d, input logic c, input logic o,
                        input logic er, input logic ev, input logic [7:0] em,
                        input logic [7:0] ei);
    vec_t r;
    r.v = v; r.d = d; r.c = c; r.o = o;
    r.er = er; r.ev = ev; r.em = em; r.ei = ei;
    vecs.push_back(r);
  endtask

  task automatic feedA(input logic [7:0] d);
    inValidA = 1'b1;
    inDataA  = d;
    tick();
    inValidA = 1'b0;
  endtask

  task automatic pulseReset(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput({name, ".inreset"}, 1'b0, 1'b0, 8'h00, 8'h00);
    checkB({name, ".inreset"}, 1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput({name, ".released"}, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput({name, ".firstedge"}, 1'b1, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    clrA = 0; inValidA = 0; inDataA = 0; outReadyA = 0;
    clrB = 0; inValidB = 0; inDataB = 0; outReadyB = 0;

    // Window 3,9,2,7 -> 9 at index 1, consumed immediately.
    addRow(1, 8'd3, 0, 1, 1, 0, 8'd0, 8'd0);
    addRow(1, 8'd9, 0, 1, 1, 0, 8'd0, 8'd0);
    addRow(1, 8'd2, 0, 1, 1, 0, 8'd0, 8'd0);
    addRow(1, 8'd7, 0, 1, 1, 0, 8'd0, 8'd0);
    addRow(0, 8'd0, 0, 1, 0, 1, 8'd9, 8'd1);
    addRow(0, 8'd0, 0, 1, 1, 0, 8'd0, 8'd0);
    // Ties: 5,5,1,5 -> earliest 5 at index 0.
    addRow(1, 8'd5, 0, 1, 1, 0, 8'd0, 8'd0);
    addRow(1, 8'd5, 0, 1, 1, 0, 8'd0, 8'd0);
    addRow(1, 8'd1, 0, 1, 1, 0, 8'd0, 8'd0);
    addRow(1, 8'd5, 0, 1, 1, 0, 8'd0, 8'd0);
    addRow(0, 8'd0, 0, 1, 0, 1, 8'd5, 8'd0);
    addRow(0, 8'd0, 0, 1, 1, 0, 8'd0, 8'd0);
    // Gaps in in_valid, then a stalled HOLD with in_valid high.
    addRow(1, 8'd8, 0, 0, 1, 0, 8'd0, 8'd0);
    addRow(0, 8'd0, 0, 0, 1, 0, 8'd0, 8'd0);
    addRow(1, 8'd2, 0, 0, 1, 0, 8'd0, 8'd0);
    addRow(0, 8'd0, 0, 0, 1, 0, 8'd0, 8'd0);
    addRow(1, 8'd1, 0, 0, 1, 0, 8'd0, 8'd0);
    addRow(1, 8'd6, 0, 0, 1, 0, 8'd0, 8'd0);
    addRow(1, 8'd200, 0, 0, 0, 1, 8'd8, 8'd0);
    addRow(1, 8'd201, 0, 0, 0, 1, 8'd8, 8'd0);
    addRow(1, 8'd202, 0, 1, 0, 1, 8'd8, 8'd0);
    addRow(0, 8'd0, 0, 1, 1, 0, 8'd0, 8'd0);
    // Rising ramp ending at full scale -> 255 at index 3.
    addRow(1, 8'd1, 0, 1, 1, 0, 8'd0, 8'd0);
    addRow(1, 8'd2, 0, 1, 1, 0, 8'd0, 8'd0);
    addRow(1, 8'd3, 0, 1, 1, 0, 8'd0, 8'd0);
    addRow(1, 8'd255, 0, 1, 1, 0, 8'd0, 8'd0);
    addRow(0, 8'd0, 0, 1, 0, 1, 8'd255, 8'd3);
    addRow(0, 8'd0, 0, 1, 1, 0, 8'd0, 8'd0);

    #3;
    checkOutput("reset", 1'b0, 1'b0, 8'h00, 8'h00);
    checkB("reset", 1'b0, 1'b0, 8'h00, 8'h00);
    #9;
    rst_n = 1'b1;
    #1;
    checkOutput("released", 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("firstedge", 1'b1, 1'b0, 8'h00, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].er, vecs[i].ev, vecs[i].em, vecs[i].ei);
      tick();
    end
    inValidA = 0; clrA = 0; outReadyA = 0;

    // Five stalled cycles in HOLD with a sample waiting upstream.
    feedA(8'd10); feedA(8'd40); feedA(8'd40); feedA(8'd30);
    inValidA = 1'b1;
    inDataA  = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall%0d", i), 1'b0, 1'b1, 8'd40, 8'd1);
      tick();
    end
    outReadyA = 1'b1;
    tick();
    inValidA = 1'b0;
    checkOutput("stall.idle", 1'b1, 1'b0, 8'd0, 8'd0);
    feedA(8'd4); feedA(8'd3); feedA(8'd2);
    checkOutput("stall.next.accum", 1'b1, 1'b0, 8'd0, 8'd0);
    feedA(8'd1);
    checkOutput("stall.next", 1'b0, 1'b1, 8'd4, 8'd0);
    tick();

    // clr mid-window with a coincident sample.
    feedA(8'd10); feedA(8'd20);
    inValidA = 1'b1; inDataA = 8'd99; clrA = 1'b1;
    tick();
    inValidA = 1'b0; clrA = 1'b0;
    checkOutput("clr.idle", 1'b1, 1'b0, 8'd0, 8'd0);
    feedA(8'd1); feedA(8'd2); feedA(8'd3);
    checkOutput("clr.accum", 1'b1, 1'b0, 8'd0, 8'd0);
    feedA(8'd4);
    checkOutput("clr.result", 1'b0, 1'b1, 8'd4, 8'd3);
    tick();
    checkOutput("clr.consumed", 1'b1, 1'b0, 8'd0, 8'd0);

    // clr in HOLD together with out_ready drops the result.
    feedA(8'd7); feedA(8'd7); feedA(8'd7); feedA(8'd7);
    clrA = 1'b1;
    checkOutput("clrhold.before", 1'b0, 1'b1, 8'd7, 8'd0);
    tick();
    clrA = 1'b0;
    checkOutput("clrhold.after", 1'b1, 1'b0, 8'd0, 8'd0);
    feedA(8'd9); feedA(8'd8); feedA(8'd7); feedA(8'd6);
    checkOutput("clrhold.next", 1'b0, 1'b1, 8'd9, 8'd0);
    tick();

    // Asynchronous reset mid-ACCUM.
    feedA(8'd50); feedA(8'd60);
    pulseReset("rstaccum");
    feedA(8'd6); feedA(8'd1); feedA(8'd1); feedA(8'd1);
    checkOutput("rstaccum.next", 1'b0, 1'b1, 8'd6, 8'd0);
    tick();

    // Asynchronous reset mid-HOLD.
    outReadyA = 1'b0;
    feedA(8'd2); feedA(8'd3); feedA(8'd4); feedA(8'd5);
    checkOutput("rsthold.hold", 1'b0, 1'b1, 8'd5, 8'd3);
    tick();
    pulseReset("rsthold");
    outReadyA = 1'b1;
    feedA(8'd0); feedA(8'd0); feedA(8'd0); feedA(8'd0);
    checkOutput("rsthold.zeros", 1'b0, 1'b1, 8'd0, 8'd0);
    tick();
    checkOutput("rsthold.idle", 1'b1, 1'b0, 8'd0, 8'd0);

    // WINDOW=1: the first sample goes straight to HOLD.
    inValidB = 1'b1; inDataB = 8'hFF; outReadyB = 1'b0;
    checkB("w1.idle", 1'b1, 1'b0, 8'h00, 8'h00);
    tick();
    inDataB = 8'h11;
    checkB("w1.hold0", 1'b0, 1'b1, 8'hFF, 8'h00);
    tick();
    checkB("w1.hold1", 1'b0, 1'b1, 8'hFF, 8'h00);
    outReadyB = 1'b1;
    tick();
    inValidB = 1'b0;
    checkB("w1.consumed", 1'b1, 1'b0, 8'h00, 8'h00);
    inValidB = 1'b1; inDataB = 8'h00;
    tick();
    inValidB = 1'b0;
    checkB("w1.zero", 1'b0, 1'b1, 8'h00, 8'h00);
    tick();
    checkB("w1.zero.consumed", 1'b1, 1'b0, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
